// File: rtl/rp_gate_pkg.sv
// rtl/rp_gate_pkg.sv - Shared types and constants for the reconfigurable-partition ingress gate
// Purpose: gate state enum and statistics counter width used by rp_ingress_gate and rp_gate_stats.
// Ports: none (package).
package rp_gate_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    PASS      = 2'd0,
    DRAIN     = 2'd1,
    DECOUPLED = 2'd2,
    DISCARD   = 2'd3
  } gate_state_e;

endpackage

// File: rtl/rp_gate_stats.sv
// rtl/rp_gate_stats.sv - Saturating packet counter with synchronous clear
// Purpose: counts single-cycle increment pulses, sticks at all-ones, clear wins over increment.
// Ports:
//   clk_i  in   clock (rising edge)
//   rst_i  in   asynchronous active-high reset, clears the count
//   clr_i  in   synchronous clear
//   inc_i  in   increment pulse
//   cnt_o  out  CNT_W-bit count
module rp_gate_stats
  import rp_gate_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rp_ingress_gate.sv
// rtl/rp_ingress_gate.sv - Packet-boundary decoupling gate in front of a reconfigurable partition
// Purpose: forwards the upstream stream with zero latency; on decouple_req it lets the current
//   packet finish, then isolates the partition (sinking or backpressuring upstream beats) and
//   re-opens only at a packet boundary. Optional statistics counters under macro RP_GATE_STATS_EN.
// Ports:
//   axis_aclk, axis_reset            clock, asynchronous active-high reset
//   s_axis_t{data,keep,user,valid,last}/s_axis_tready   upstream stream
//   m_axis_t{data,keep,user,valid,last}/m_axis_tready   stream into the partition
//   decouple_req / decouple_ack      isolation request and registered acknowledge
//   stats_clr, pkt_cnt, drop_cnt     counter clear, forwarded / dropped packet counts
module rp_ingress_gate
  import rp_gate_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH   = 256,
  parameter int C_AXIS_TUSER_WIDTH  = 128,
  parameter int DROP_WHEN_DECOUPLED = 1
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic                            decouple_req,
  output logic                            decouple_ack,
  input  logic                            stats_clr,
  output logic [CNT_W-1:0]                pkt_cnt,
  output logic [CNT_W-1:0]                drop_cnt
);

  localparam logic SINK_READY = (DROP_WHEN_DECOUPLED != 0);

  gate_state_e state_q, state_d;
  logic        in_pkt_q, in_pkt_d;
  logic        ack_q, ack_d;
  logic        fwd_en, sink_en, accept, fwd_last, drop_last;

  // Data sideband is a straight wire; only valid/ready are gated.
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tkeep = s_axis_tkeep;
  assign m_axis_tuser = s_axis_tuser;
  assign m_axis_tlast = s_axis_tlast;

  assign accept    = s_axis_tvalid & s_axis_tready;
  assign fwd_last  = fwd_en & accept & s_axis_tlast;
  assign drop_last = sink_en & accept & s_axis_tlast;

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q  <= PASS;
      in_pkt_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_pkt_q <= in_pkt_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_pkt_d = accept ? ~s_axis_tlast : in_pkt_q;
    case (state_q)
      // in_pkt_d folds in this cycle's beat: a request that arrives together with a
      // tlast beat isolates straight away instead of draining the following packet.
      PASS:      if (decouple_req) state_d = in_pkt_d ? DRAIN : DECOUPLED;
      // The request is not looked at while draining; the packet always completes.
      DRAIN:     if (accept && s_axis_tlast) state_d = DECOUPLED;
      DECOUPLED: if (!decouple_req) state_d = in_pkt_d ? DISCARD : PASS;
      DISCARD:   if (accept && s_axis_tlast) state_d = PASS;
      default:   state_d = PASS;
    endcase
    ack_d = (state_d == DECOUPLED) || (state_d == DISCARD);
  end

  always_comb begin
    fwd_en  = 1'b0;
    sink_en = 1'b0;
    case (state_q)
      // A pending request at a packet boundary blocks the start of a new packet.
      PASS:    fwd_en = ~(decouple_req & ~in_pkt_q);
      DRAIN:   fwd_en = 1'b1;
      default: sink_en = 1'b1;
    endcase
    m_axis_tvalid = fwd_en & s_axis_tvalid;
    // m_axis_tready is undefined during reconfiguration, so it is only selected while forwarding.
    if (fwd_en) begin
      s_axis_tready = m_axis_tready;
    end else begin
      s_axis_tready = sink_en & SINK_READY;
    end
  end

  assign decouple_ack = ack_q;

`ifdef RP_GATE_STATS_EN
  rp_gate_stats u_pkt_stats (
    .clk_i (axis_aclk),
    .rst_i (axis_reset),
    .clr_i (stats_clr),
    .inc_i (fwd_last),
    .cnt_o (pkt_cnt)
  );

  rp_gate_stats u_drop_stats (
    .clk_i (axis_aclk),
    .rst_i (axis_reset),
    .clr_i (stats_clr),
    .inc_i (drop_last),
    .cnt_o (drop_cnt)
  );
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
  logic unused_stats;
  assign unused_stats = ^{stats_clr, fwd_last, drop_last};
`endif

endmodule
